// File: rtl/led_pattern_gen.sv
// Multi-pattern LED running light: prescaled step tick drives rotate, bounce or fill
// patterns across LED_NUM outputs, with run/pause, speed select and a wrap strobe.
module led_pattern_gen #(
    parameter int               LED_NUM    = 8,
    parameter int               CNT_W      = 25,
    parameter logic [CNT_W-1:0] CNT_MAX    = 25'd24_999_999,
    parameter bit               ACTIVE_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         mode,
    input  logic               run,
    input  logic [1:0]         speed,
    output logic [LED_NUM-1:0] led_out,
    output logic               tick,
    output logic               wrap
);

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [LED_NUM-1:0] PAT_LSB = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] PAT_MSB = PAT_LSB << (LED_NUM - 1);
    localparam logic [LED_NUM-1:0] PAT_ALL = {LED_NUM{1'b1}};

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   limit;
    logic [1:0]         mode_q;
    logic               dir;
    logic               dir_nxt;
    logic [LED_NUM-1:0] pat;
    logic [LED_NUM-1:0] pat_nxt;
    logic [LED_NUM-1:0] start_new;
    logic [LED_NUM-1:0] start_cur;
    logic               mode_chg;
    logic               step;
    logic               wrap_nxt;

    function automatic logic [LED_NUM-1:0] start_of(input logic [1:0] m);
        return (m == MODE_ROT_R) ? PAT_MSB : PAT_LSB;
    endfunction

    assign limit     = CNT_MAX >> speed;
    assign mode_chg  = (mode != mode_q);
    assign step      = tick && run;
    assign start_new = start_of(mode);
    assign start_cur = start_of(mode_q);
    assign led_out   = ACTIVE_LOW ? ~pat : pat;

    // Next pattern for one step in the currently registered mode.
    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        if (pat == '0) begin
            pat_nxt = start_cur;
            dir_nxt = DIR_UP;
        end else begin
            case (mode_q)
                MODE_ROT_L: pat_nxt = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
                MODE_ROT_R: pat_nxt = {pat[0], pat[LED_NUM-1:1]};
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        pat_nxt = pat << 1;
                        if (pat_nxt == PAT_MSB) dir_nxt = DIR_DOWN;
                    end else begin
                        pat_nxt = pat >> 1;
                        if (pat_nxt == PAT_LSB) dir_nxt = DIR_UP;
                    end
                end
                MODE_FILL: pat_nxt = (pat == PAT_ALL) ? PAT_LSB : ((pat << 1) | PAT_LSB);
                default:   pat_nxt = start_cur;
            endcase
        end
    end

    // Recovery from an all-zero pattern is not counted as a wrap.
    assign wrap_nxt = (pat != '0) && (pat_nxt == start_cur);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt    <= '0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
            mode_q <= MODE_ROT_L;
            dir    <= DIR_UP;
            pat    <= PAT_LSB;
        end else begin
            mode_q <= mode;
            if (mode_chg) begin
                pat  <= start_new;
                dir  <= DIR_UP;
                cnt  <= '0;
                tick <= 1'b0;
                wrap <= 1'b0;
            end else begin
                if (run) begin
                    if (cnt >= limit) begin
                        cnt  <= '0;
                        tick <= 1'b1;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        tick <= 1'b0;
                    end
                end else begin
                    tick <= 1'b0;
                end

                if (step) begin
                    pat  <= pat_nxt;
                    dir  <= dir_nxt;
                    wrap <= wrap_nxt;
                end else begin
                    wrap <= 1'b0;
                end
            end
        end
    end

endmodule
